vector_register_file_masked: RTL and testbench

- Parametrised vector register file for the vector processing element.
- Provides NUM_REGS registers, each NUM_ELEMS x ELEM_WIDTH bits wide.
- Two combinational read ports and one element-masked write port (ALU writeback).
- A multi-beat load port fills one register from a narrower Data Memory bus under a valid/ready handshake, run by a beat-counting FSM.

---
 rtl/vector_register_file_masked_if.sv | 47 ++++
 rtl/vector_register_file_masked.sv | 124 ++++++++++++
 tb/tb_vector_register_file_masked.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/vector_register_file_masked_if.sv
// -----------------------------------------------------------------------------
// vector_register_file_masked_if
// Groups the vector register file's read, writeback and load-bus signals.
//   master : drives addresses, writeback and load beats (pipeline / memory side)
//   slave  : the register file itself
// Signals:
//   A1, A2         read addresses         RD1, RD2  read data (REG_WIDTH)
//   WE3, A3, WD3   masked writeback       WM3       per-element write mask
//   ld_start, ld_addr                     start a load into a register
//   ld_valid, ld_data, ld_ready           beat handshake (BEAT_WIDTH)
//   ld_busy, ld_done                      load status
// -----------------------------------------------------------------------------
interface vector_register_file_masked_if #(
   parameter int NUM_REGS   = 32,
   parameter int ELEM_WIDTH = 32,
   parameter int NUM_ELEMS  = 8,
   parameter int BEAT_WIDTH = 64,
   parameter int ADDR_W     = 5
) ();
   localparam int REG_WIDTH = ELEM_WIDTH * NUM_ELEMS;

   logic [ADDR_W-1:0]     A1;
   logic [ADDR_W-1:0]     A2;
   logic [REG_WIDTH-1:0]  RD1;
   logic [REG_WIDTH-1:0]  RD2;
   logic                  WE3;
   logic [ADDR_W-1:0]     A3;
   logic [REG_WIDTH-1:0]  WD3;
   logic [NUM_ELEMS-1:0]  WM3;
   logic                  ld_start;
   logic [ADDR_W-1:0]     ld_addr;
   logic                  ld_valid;
   logic [BEAT_WIDTH-1:0] ld_data;
   logic                  ld_ready;
   logic                  ld_busy;
   logic                  ld_done;

   modport master (
      output A1, A2, WE3, A3, WD3, WM3, ld_start, ld_addr, ld_valid, ld_data,
      input  RD1, RD2, ld_ready, ld_busy, ld_done
   );

   modport slave (
      input  A1, A2, WE3, A3, WD3, WM3, ld_start, ld_addr, ld_valid, ld_data,
      output RD1, RD2, ld_ready, ld_busy, ld_done
   );
endinterface

// File: rtl/vector_register_file_masked.sv
// -----------------------------------------------------------------------------
// vector_register_file_masked
// NUM_REGS vector registers of NUM_ELEMS x ELEM_WIDTH bits with two
// combinational read ports, one element-masked writeback port, and a
// multi-beat load port that fills one register from a BEAT_WIDTH bus.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset (clears every register and the FSM)
//   bus  vector_register_file_masked_if.slave (read/write/load signals)
// Optional build macro VRF_WRITE_BYPASS_EN: forwards masked writeback data
// to a read port addressing the register being written in the same cycle.
// -----------------------------------------------------------------------------
module vector_register_file_masked #(
   parameter int NUM_REGS   = 32,
   parameter int ELEM_WIDTH = 32,
   parameter int NUM_ELEMS  = 8,
   parameter int BEAT_WIDTH = 64,
   parameter int ADDR_W     = 5
) (
   input  logic                             clk,
   input  logic                             rst,
   vector_register_file_masked_if.slave     bus
);
   localparam int REG_WIDTH = ELEM_WIDTH * NUM_ELEMS;
   localparam int BEATS     = REG_WIDTH / BEAT_WIDTH;
   localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [REG_WIDTH-1:0] regs_q [NUM_REGS];
   logic [REG_WIDTH-1:0] regs_d [NUM_REGS];
   logic                 beat_acc;

   // Load FSM: next state and handshake outputs
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      bus.ld_ready = 1'b0;
      bus.ld_busy  = 1'b0;
      bus.ld_done  = 1'b0;
      beat_acc     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.ld_start) begin
               addr_d  = bus.ld_addr;
               cnt_d   = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            bus.ld_ready = 1'b1;
            bus.ld_busy  = 1'b1;
            if (bus.ld_valid) begin
               beat_acc = 1'b1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(BEATS - 1)) state_d = DONE;
            end
         end
         DONE: begin
            bus.ld_done = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Register next state: masked writeback first, then the load beat
   // overrides its slice so load bits win on a same-register conflict.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         regs_d[r] = regs_q[r];
         if (bus.WE3 && (bus.A3 == ADDR_W'(r))) begin
            for (int e = 0; e < NUM_ELEMS; e++) begin
               if (bus.WM3[e])
                  regs_d[r][e*ELEM_WIDTH +: ELEM_WIDTH] = bus.WD3[e*ELEM_WIDTH +: ELEM_WIDTH];
            end
         end
         if (beat_acc && (addr_q == ADDR_W'(r)))
            regs_d[r][int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = bus.ld_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
      end
   end

`ifdef VRF_WRITE_BYPASS_EN
   // Forward only the masked writeback elements; load beats are not bypassed.
   function automatic logic [REG_WIDTH-1:0] bypass(
      input logic [REG_WIDTH-1:0] stored,
      input logic                 hit,
      input logic [REG_WIDTH-1:0] wd,
      input logic [NUM_ELEMS-1:0] wm
   );
      logic [REG_WIDTH-1:0] v;
      v = stored;
      for (int e = 0; e < NUM_ELEMS; e++) begin
         if (hit && wm[e]) v[e*ELEM_WIDTH +: ELEM_WIDTH] = wd[e*ELEM_WIDTH +: ELEM_WIDTH];
      end
      return v;
   endfunction

   assign bus.RD1 = bypass(regs_q[bus.A1], bus.WE3 && (bus.A1 == bus.A3), bus.WD3, bus.WM3);
   assign bus.RD2 = bypass(regs_q[bus.A2], bus.WE3 && (bus.A2 == bus.A3), bus.WD3, bus.WM3);
`else
   assign bus.RD1 = regs_q[bus.A1];
   assign bus.RD2 = regs_q[bus.A2];
`endif

endmodule

// File: tb/tb_vector_register_file_masked.sv
module tb_vector_register_file_masked;
   localparam int RW = 256;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   vector_register_file_masked_if #(
      .NUM_REGS(32), .ELEM_WIDTH(32), .NUM_ELEMS(8), .BEAT_WIDTH(64), .ADDR_W(5)
   ) vif ();

   vector_register_file_masked #(
      .NUM_REGS(32), .ELEM_WIDTH(32), .NUM_ELEMS(8), .BEAT_WIDTH(64), .ADDR_W(5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   logic [RW-1:0]  exp_v, stored3;
   logic [63:0]    b0, b1, b2, b3, c0, c1;

   initial begin
      checks = 0; failures = 0;
      rst = 1'b0;
      vif.A1 = '0; vif.A2 = '0; vif.WE3 = 1'b0; vif.A3 = '0; vif.WD3 = '0; vif.WM3 = '0;
      vif.ld_start = 1'b0; vif.ld_addr = '0; vif.ld_valid = 1'b0; vif.ld_data = '0;
      b0 = 64'hAAAA_0000_0000_0010; b1 = 64'hAAAA_1111_0000_0011;
      b2 = 64'hAAAA_2222_0000_0012; b3 = 64'hAAAA_3333_0000_0013;
      c0 = 64'hC0C0_C0C0_0BAD_F00D; c1 = 64'hC1C1_C1C1_1234_5678;

      // Reset state
      #12;
      chk("rst_rd1", vif.RD1, '0);
      chk("rst_ready", RW'(vif.ld_ready), '0);
      chk("rst_busy", RW'(vif.ld_busy), '0);
      chk("rst_done", RW'(vif.ld_done), '0);
      rst = 1'b1;
      tick();

      // Full-mask write to reg5
      vif.WE3 = 1'b1; vif.A3 = 5'd5; vif.WM3 = 8'hFF;
      vif.WD3 = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
      vif.A1 = 5'd5; vif.A2 = 5'd6;
      settle();
`ifdef VRF_WRITE_BYPASS_EN
      chk("pre_edge_rd1", vif.RD1, {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8});
`else
      chk("pre_edge_rd1", vif.RD1, '0);
`endif
      tick();
      vif.WE3 = 1'b0;
      settle();
      chk("wr_full_rd1", vif.RD1, {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8});
      chk("wr_full_rd2_other", vif.RD2, '0);

      // Partial mask: low four elements
      vif.WE3 = 1'b1; vif.A3 = 5'd5; vif.WM3 = 8'h0F; vif.WD3 = {RW{1'b1}};
      tick();
      vif.WE3 = 1'b0;
      settle();
      chk("wr_mask0F", vif.RD1, {32'd1, 32'd2, 32'd3, 32'd4, {4{32'hFFFF_FFFF}}});

      // Zero mask writes nothing
      vif.WE3 = 1'b1; vif.A3 = 5'd5; vif.WM3 = 8'h00; vif.WD3 = '0;
      tick();
      vif.WE3 = 1'b0;
      settle();
      chk("wr_mask00", vif.RD1, {32'd1, 32'd2, 32'd3, 32'd4, {4{32'hFFFF_FFFF}}});

      // Register 0 is writable
      vif.WE3 = 1'b1; vif.A3 = 5'd0; vif.WM3 = 8'hA5; vif.WD3 = {8{32'h1234_5678}};
      tick();
      vif.WE3 = 1'b0; vif.A2 = 5'd0;
      settle();
      chk("wr_reg0", vif.RD2, {32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0,
                               32'h0, 32'h1234_5678, 32'h0, 32'h1234_5678});

      // Load into reg7 with a 2-cycle stall and an ignored restart
      vif.ld_start = 1'b1; vif.ld_addr = 5'd7;
      tick();
      vif.ld_start = 1'b0; vif.ld_valid = 1'b1; vif.ld_data = b0;
      settle();
      chk("load_ready", RW'(vif.ld_ready), RW'(1));
      chk("load_busy", RW'(vif.ld_busy), RW'(1));
      tick();
      vif.ld_valid = 1'b0; vif.ld_start = 1'b1; vif.ld_addr = 5'd9; vif.A1 = 5'd7;
      settle();
      chk("load_partial", vif.RD1, {192'h0, b0});
      tick();
      vif.ld_start = 1'b0;
      settle();
      chk("stall_ready", RW'(vif.ld_ready), RW'(1));
      chk("stall_done", RW'(vif.ld_done), '0);
      tick();
      vif.ld_valid = 1'b1; vif.ld_data = b1; tick();
      vif.ld_data = b2; tick();
      vif.ld_data = b3;
      settle();
      chk("last_beat_no_done", RW'(vif.ld_done), '0);
      tick();
      vif.ld_valid = 1'b0; vif.ld_start = 1'b1; vif.ld_addr = 5'd9;
      settle();
      chk("done_pulse", RW'(vif.ld_done), RW'(1));
      chk("done_busy", RW'(vif.ld_busy), '0);
      chk("done_ready", RW'(vif.ld_ready), '0);
      tick();
      vif.ld_start = 1'b0;
      settle();
      chk("idle_after_done_busy", RW'(vif.ld_busy), '0);
      chk("idle_after_done_done", RW'(vif.ld_done), '0);
      chk("load_reg7", vif.RD1, {b3, b2, b1, b0});
      vif.A2 = 5'd9;
      settle();
      chk("restart_ignored_reg9", vif.RD2, '0);

      // Same-edge conflict, then reset aborts the load after two beats
      vif.ld_start = 1'b1; vif.ld_addr = 5'd7;
      tick();
      vif.ld_start = 1'b0; vif.ld_valid = 1'b1; vif.ld_data = c0;
      vif.WE3 = 1'b1; vif.A3 = 5'd7; vif.WM3 = 8'hFF; vif.WD3 = {RW{1'b1}};
      tick();
      vif.WE3 = 1'b0;
      settle();
      chk("conflict", vif.RD1, {{192{1'b1}}, c0});
      vif.ld_data = c1;
      tick();
      vif.ld_valid = 1'b0;
      settle();
      chk("two_beats", vif.RD1, {{128{1'b1}}, c1, c0});
      rst = 1'b0;
      settle();
      chk("abort_reg7", vif.RD1, '0);
      chk("abort_busy", RW'(vif.ld_busy), '0);
      chk("abort_ready", RW'(vif.ld_ready), '0);
      tick();
      rst = 1'b1;
      tick();
      chk("abort_no_done", RW'(vif.ld_done), '0);

      // Back-to-back load after release
      vif.ld_start = 1'b1; vif.ld_addr = 5'd7;
      tick();
      vif.ld_start = 1'b0; vif.ld_valid = 1'b1;
      vif.ld_data = b3; tick();
      vif.ld_data = b2; tick();
      vif.ld_data = b1; tick();
      vif.ld_data = b0; tick();
      vif.ld_valid = 1'b0;
      settle();
      chk("reload_done", RW'(vif.ld_done), RW'(1));
      chk("reload_reg7", vif.RD1, {b0, b1, b2, b3});
      tick();

      // Same-cycle read of a register being written
      stored3 = {32'h37, 32'h36, 32'h35, 32'h34, 32'h33, 32'h32, 32'h31, 32'h30};
      vif.WE3 = 1'b1; vif.A3 = 5'd3; vif.WM3 = 8'hFF; vif.WD3 = stored3;
      tick();
      vif.A1 = 5'd3; vif.A2 = 5'd3; vif.WM3 = 8'h01;
      vif.WD3 = {{7{32'h5555_5555}}, 32'hDEAD_BEEF};
      exp_v = {stored3[255:32], 32'hDEAD_BEEF};
      settle();
`ifdef VRF_WRITE_BYPASS_EN
      chk("bypass_rd1", vif.RD1, exp_v);
      chk("bypass_rd2", vif.RD2, exp_v);
`else
      chk("nobypass_rd1", vif.RD1, stored3);
      chk("nobypass_rd2", vif.RD2, stored3);
`endif
      tick();
      vif.WE3 = 1'b0;
      settle();
      chk("after_edge_rd1", vif.RD1, exp_v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
